// File: rtl/bilinear_csr_pkg.sv
// Shared definitions for the bilinear downscale CSR initiator.
// Holds the CSR word map, CTRL/STATUS bit positions, the host FSM state
// encoding and the Q8.8 scale width, plus a helper that builds the CTRL
// base word from the latched job mode bits.
package bilinear_csr_pkg;

  localparam int Q_W = 16;  // Q8.8 inverse scale width

  // CSR word addresses
  localparam logic [3:0] A_CTRL     = 4'd0;
  localparam logic [3:0] A_STATUS   = 4'd1;
  localparam logic [3:0] A_SCALE_Q  = 4'd2;
  localparam logic [3:0] A_IN_WH    = 4'd3;
  localparam logic [3:0] A_OUT_WH   = 4'd4;
  localparam logic [3:0] A_PERF_CYC = 4'd5;
  localparam logic [3:0] A_PERF_PIX = 4'd6;

  // CTRL bits
  localparam int CTRL_EN        = 0;
  localparam int CTRL_START     = 1;
  localparam int CTRL_MODE      = 2;
  localparam int CTRL_STEP_MODE = 3;
  localparam int CTRL_STEP      = 4;

  // STATUS bits
  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_STEP_ACK = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SCALE, S_WR_IN, S_WR_OUT, S_WR_START, S_ARM, S_POLL,
    S_STEP_SET, S_STEP_WAIT, S_STEP_CLR, S_RD_CYC, S_RD_PIX, S_RESULT, S_ABORT
  } state_t;

  typedef struct packed {
    logic           mode;
    logic           step_mode;
    logic [15:0]    in_w;
    logic [15:0]    in_h;
    logic [15:0]    out_w;
    logic [15:0]    out_h;
    logic [Q_W-1:0] inv_scale_q;
  } desc_t;

  // CTRL word with EN set and the job's mode bits; START/STEP are OR'd on top.
  function automatic logic [31:0] ctrl_base(input logic mode, input logic step_mode);
    logic [31:0] v;
    v                 = '0;
    v[CTRL_EN]        = 1'b1;
    v[CTRL_MODE]      = mode;
    v[CTRL_STEP_MODE] = step_mode;
    return v;
  endfunction

endpackage

// File: rtl/bilinear_csr_timeout.sv
// Wait watchdog for the CSR host.
// Down-counter reloaded to TIMEOUT_CYC-1 by clr (and reset); decrements on
// each enabled cycle and flags expired once it has run out while enabled.
// Ports: clk, rst (async, active-high), clr (reload), en (count), expired.
module bilinear_csr_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= LOAD;
    else if (clr)               cnt <= LOAD;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/bilinear_csr_host.sv
// CSR initiator for the bilinear downscale accelerator.
// Accepts one job descriptor, writes SCALE_Q / IN_W_H / OUT_W_H / CTRL+START,
// waits for the run to go BUSY, polls STATUS for DONE (servicing STEP
// handshakes in stepping mode), then reads PERF_CYC / PERF_PIX and returns
// them with a one-cycle res_valid. Waits are bounded by a watchdog; on
// expiry CTRL is cleared and a zero result is returned with res_timeout.
// Ports:
//   clk, rst                       clock, async active-high reset
//   cmd_valid/cmd_ready, cmd_*     job descriptor handshake
//   step_req                       one-cycle step request (stepping mode)
//   busy                           not idle
//   res_valid, res_cycles, res_pixels, res_timeout   result
//   csr_we, csr_addr, csr_wdata    registered CSR write/address
//   csr_rdata                      combinational read data for csr_addr
module bilinear_csr_host
  import bilinear_csr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int ARM_GUARD   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_mode,
  input  logic           cmd_step_mode,
  input  logic [15:0]    cmd_in_w,
  input  logic [15:0]    cmd_in_h,
  input  logic [15:0]    cmd_out_w,
  input  logic [15:0]    cmd_out_h,
  input  logic [Q_W-1:0] cmd_inv_scale_q,
  input  logic           step_req,
  output logic           busy,
  output logic           res_valid,
  output logic [31:0]    res_cycles,
  output logic [31:0]    res_pixels,
  output logic           res_timeout,
  output logic           csr_we,
  output logic [3:0]     csr_addr,
  output logic [31:0]    csr_wdata,
  input  logic [31:0]    csr_rdata
);

  localparam int AGW = (ARM_GUARD > 0) ? $clog2(ARM_GUARD + 1) : 1;

  localparam logic [31:0] START_M = 32'(1) << CTRL_START;
  localparam logic [31:0] STEP_M  = 32'(1) << CTRL_STEP;

  state_t          state, nxt;
  desc_t           desc;
  logic [AGW-1:0]  guard;
  logic            accept;
  logic            tmo_en, tmo_exp;
  logic [31:0]     base;

  assign accept = cmd_valid && cmd_ready;
  assign base   = ctrl_base(desc.mode, desc.step_mode);

  // Watchdog runs only while waiting on hardware: ARM past the guard,
  // STEP_WAIT, and POLL when no software stepping is involved.
  assign tmo_en = (state == S_ARM && guard == '0) ||
                  (state == S_STEP_WAIT) ||
                  (state == S_POLL && !desc.step_mode);

  bilinear_csr_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (nxt != state),
    .en      (tmo_en),
    .expired (tmo_exp)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:      if (accept) nxt = S_WR_SCALE;
      S_WR_SCALE:  nxt = S_WR_IN;
      S_WR_IN:     nxt = S_WR_OUT;
      S_WR_OUT:    nxt = S_WR_START;
      S_WR_START:  nxt = S_ARM;
      // Only BUSY matters here: DONE may still be set from the last run.
      S_ARM: if (guard == '0) begin
        if (csr_rdata[ST_BUSY]) nxt = S_POLL;
        else if (tmo_exp)       nxt = S_ABORT;
      end
      S_POLL: begin
        if (csr_rdata[ST_DONE])               nxt = S_RD_CYC;
        else if (desc.step_mode && step_req)  nxt = S_STEP_SET;
        else if (tmo_exp)                     nxt = S_ABORT;
      end
      S_STEP_SET:  nxt = S_STEP_WAIT;
      S_STEP_WAIT: begin
        if (csr_rdata[ST_STEP_ACK]) nxt = S_STEP_CLR;
        else if (tmo_exp)           nxt = S_ABORT;
      end
      S_STEP_CLR:  nxt = S_POLL;
      S_RD_CYC:    nxt = S_RD_PIX;
      S_RD_PIX:    nxt = S_RESULT;
      S_RESULT:    nxt = S_IDLE;
      S_ABORT:     nxt = S_RESULT;
      default:     nxt = S_IDLE;
    endcase
  end

  // State and all outputs are registered from the next state so the CSR
  // bus presents each state's access during the cycle the state is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      desc        <= '0;
      guard       <= '0;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_cycles  <= '0;
      res_pixels  <= '0;
      res_timeout <= 1'b0;
      csr_we      <= 1'b0;
      csr_addr    <= A_STATUS;
      csr_wdata   <= '0;
    end else begin
      state     <= nxt;
      cmd_ready <= (nxt == S_IDLE);
      busy      <= (nxt != S_IDLE);
      res_valid <= (nxt == S_RESULT);

      csr_we    <= 1'b0;
      csr_addr  <= A_STATUS;
      csr_wdata <= '0;
      unique case (nxt)
        S_WR_SCALE: begin  // entered only on accept, so use the live command
          csr_we    <= 1'b1;
          csr_addr  <= A_SCALE_Q;
          csr_wdata <= 32'(cmd_inv_scale_q);
        end
        S_WR_IN: begin
          csr_we    <= 1'b1;
          csr_addr  <= A_IN_WH;
          csr_wdata <= {desc.in_w, desc.in_h};
        end
        S_WR_OUT: begin
          csr_we    <= 1'b1;
          csr_addr  <= A_OUT_WH;
          csr_wdata <= {desc.out_w, desc.out_h};
        end
        S_WR_START: begin
          csr_we    <= 1'b1;
          csr_addr  <= A_CTRL;
          csr_wdata <= base | START_M;
        end
        S_STEP_SET: begin
          csr_we    <= 1'b1;
          csr_addr  <= A_CTRL;
          csr_wdata <= base | STEP_M;
        end
        S_STEP_CLR: begin
          csr_we    <= 1'b1;
          csr_addr  <= A_CTRL;
          csr_wdata <= base;
        end
        S_ABORT: begin
          csr_we    <= 1'b1;
          csr_addr  <= A_CTRL;
        end
        S_RD_CYC:   csr_addr <= A_PERF_CYC;
        S_RD_PIX:   csr_addr <= A_PERF_PIX;
        default: ;
      endcase

      if (state == S_IDLE && accept) begin
        desc.mode        <= cmd_mode;
        desc.step_mode   <= cmd_step_mode;
        desc.in_w        <= cmd_in_w;
        desc.in_h        <= cmd_in_h;
        desc.out_w       <= cmd_out_w;
        desc.out_h       <= cmd_out_h;
        desc.inv_scale_q <= cmd_inv_scale_q;
        res_cycles       <= '0;
        res_pixels       <= '0;
        res_timeout      <= 1'b0;
      end

      if (state == S_RD_CYC) res_cycles <= csr_rdata;
      if (state == S_RD_PIX) res_pixels <= csr_rdata;
      if (state == S_ABORT) begin
        res_timeout <= 1'b1;
        res_cycles  <= '0;
        res_pixels  <= '0;
      end

      if (nxt == S_ARM && state != S_ARM)   guard <= AGW'(ARM_GUARD);
      else if (state == S_ARM && guard != '0) guard <= guard - 1'b1;
    end
  end

endmodule

// File: tb/tb_bilinear_csr_host.sv
// Self-checking bench for bilinear_csr_host against a small accelerator stub.
module tb_bilinear_csr_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_mode = 1'b0, cmd_step_mode = 1'b0;
  logic [15:0] cmd_in_w = '0, cmd_in_h = '0, cmd_out_w = '0, cmd_out_h = '0, cmd_inv_scale_q = '0;
  logic        step_req = 1'b0, busy, res_valid, res_timeout, csr_we;
  logic [31:0] res_cycles, res_pixels, csr_wdata, csr_rdata;
  logic [3:0]  csr_addr;

  bilinear_csr_host #(.TIMEOUT_CYC(16), .ARM_GUARD(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_step_mode(cmd_step_mode),
    .cmd_in_w(cmd_in_w), .cmd_in_h(cmd_in_h), .cmd_out_w(cmd_out_w), .cmd_out_h(cmd_out_h),
    .cmd_inv_scale_q(cmd_inv_scale_q), .step_req(step_req), .busy(busy),
    .res_valid(res_valid), .res_cycles(res_cycles), .res_pixels(res_pixels),
    .res_timeout(res_timeout), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic m, sm;
    logic [15:0] iw, ih, ow, oh, sc;
  } job_t;
  typedef struct { int c; logic [3:0] a; logic [31:0] d; } wr_t;

  int errs = 0, checks = 0;
  int cyc = 0;
  wr_t wq[$];
  int  acc_q[$];
  int  nres = 0, res_cyc = 0;
  logic [31:0] rc = '0, rp = '0;
  logic rt = 1'b0;

  // ---------------- accelerator stub ----------------
  int   bdly = 2, run_len = 6;
  bit   never_done = 0;
  logic [31:0] perf_c = '0, perf_p = '0;
  logic st_busy, st_done, st_ack, st_stepm;
  int   pend, run, ackc, steps, done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_busy <= 0; st_done <= 0; st_ack <= 0; st_stepm <= 0;
      pend <= 0; run <= 0; ackc <= 0; steps <= 0; done_cyc <= -1;
    end else begin
      if (pend != 0) begin
        pend <= pend - 1;
        if (pend == 1) begin st_busy <= 1; st_done <= 0; run <= run_len; end
      end else if (st_busy && !st_stepm && !never_done) begin
        if (run <= 1) begin st_busy <= 0; st_done <= 1; done_cyc <= cyc + 1; end
        else run <= run - 1;
      end
      if (ackc != 0) begin
        ackc <= ackc - 1;
        if (ackc == 1) st_ack <= 1;
      end
      if (csr_we && csr_addr == 4'd0) begin
        if (csr_wdata[1]) begin
          pend <= bdly; st_busy <= 0; steps <= 0; st_stepm <= csr_wdata[3];
        end else if (csr_wdata[4]) ackc <= 4;
        else if (csr_wdata == 32'h0) st_busy <= 0;
        else begin
          st_ack <= 0; steps <= steps + 1;
          if (steps == 2) begin st_busy <= 0; st_done <= 1; done_cyc <= cyc + 1; end
        end
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      4'd1: csr_rdata = {28'h0, st_ack, 1'b0, st_done, st_busy};
      4'd5: csr_rdata = perf_c;
      4'd6: csr_rdata = perf_p;
      default: csr_rdata = '0;
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (csr_we) wq.push_back('{cyc, csr_addr, csr_wdata});
    if (cmd_valid && cmd_ready && !rst) acc_q.push_back(cyc);
    if (res_valid) begin
      nres <= nres + 1; res_cyc <= cyc;
      rc <= res_cycles; rp <= res_pixels; rt <= res_timeout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_step();
    @(posedge clk); #1 step_req = 1'b1;
    @(posedge clk); #1 step_req = 1'b0;
  endtask

  task automatic drive_cmd(input job_t j);
    cmd_mode = j.m; cmd_step_mode = j.sm;
    cmd_in_w = j.iw; cmd_in_h = j.ih; cmd_out_w = j.ow; cmd_out_h = j.oh;
    cmd_inv_scale_q = j.sc;
  endtask

  task automatic start_job(input job_t j, output int t_acc, output int wb);
    int a0;
    @(posedge clk); #1;
    wb = wq.size(); a0 = acc_q.size(); t_acc = -100;
    drive_cmd(j); cmd_valid = 1'b1;
    for (int i = 0; i < 20 && acc_q.size() == a0; i++) begin @(negedge clk); #1; end
    chk("accept", 32'(acc_q.size() - a0), 32'd1);
    if (acc_q.size() > a0) t_acc = acc_q[a0];
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input int bound);
    int  n0;
    bit  seen;
    n0 = nres; seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin @(negedge clk); #1; seen = (nres != n0); end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_busy();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); #1; seen = st_busy; end
    chk("stub_busy", 32'(seen), 32'd1);
  endtask

  // Expected CSR write list for a job, straight from the descriptor.
  task automatic check_writes(input int wb, input int wend, input int t_acc, input job_t j,
                              input int nsteps, input bit abort);
    logic [35:0] exp_q[$];
    logic [31:0] base;
    base = 32'h1 | (32'(j.m) << 2) | (32'(j.sm) << 3);
    exp_q.push_back({4'd2, 16'h0, j.sc});
    exp_q.push_back({4'd3, j.iw, j.ih});
    exp_q.push_back({4'd4, j.ow, j.oh});
    exp_q.push_back({4'd0, base | 32'h2});
    for (int s = 0; s < nsteps; s++) begin
      exp_q.push_back({4'd0, base | 32'h10});
      exp_q.push_back({4'd0, base});
    end
    if (abort) exp_q.push_back({4'd0, 32'h0});
    chk("wr_count", 32'(wend - wb), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && wb + k < wend; k++) begin
      chk($sformatf("wr%0d_addr", k), 32'(wq[wb+k].a), 32'(exp_q[k][35:32]));
      chk($sformatf("wr%0d_data", k), wq[wb+k].d, exp_q[k][31:0]);
      if (k < 4) chk($sformatf("wr%0d_cyc", k), 32'(wq[wb+k].c), 32'(t_acc + 1 + k));
    end
  endtask

  function automatic job_t rand_job(input logic sm);
    job_t j;
    j.m = 1'($urandom); j.sm = sm;
    j.iw = 16'($urandom); j.ih = 16'($urandom);
    j.ow = 16'($urandom); j.oh = 16'($urandom); j.sc = 16'($urandom);
    return j;
  endfunction

  task automatic plain_job(input string tag, input job_t j);
    int t, wb;
    run_len = $urandom_range(3, 10);
    perf_c = $urandom; perf_p = $urandom;
    start_job(j, t, wb);
    wait_res({tag, "_res"}, 80);
    chk({tag, "_res_cyc"}, 32'(res_cyc), 32'(done_cyc + 3));
    chk({tag, "_cycles"}, rc, perf_c);
    chk({tag, "_pixels"}, rp, perf_p);
    chk({tag, "_tmo"}, 32'(rt), 32'd0);
    check_writes(wb, wq.size(), t, j, 0, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    job_t j, j2;
    int t, wb, t1, t2, a0, wb1, wend, d1;
    bit seen;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(csr_we), 32'd0);
    chk("rst_addr", 32'(csr_addr), 32'd1);
    chk("rst_resv", 32'(res_valid), 32'd0);
    chk("rst_res", {res_cycles[15:0], res_pixels[14:0], res_timeout}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // scalar job, step_req ignored outside stepping mode
    bdly = 2; run_len = 6; perf_c = 32'h120; perf_p = 32'h300;
    j = '{m:1'b0, sm:1'b0, iw:16'd64, ih:16'd48, ow:16'd32, oh:16'd24, sc:16'h0200};
    start_job(j, t, wb);
    wait_busy();
    pulse_step();
    wait_res("scalar_res", 60);
    chk("scalar_res_cyc", 32'(res_cyc), 32'(done_cyc + 3));
    chk("scalar_cycles", rc, 32'h120);
    chk("scalar_pixels", rp, 32'h300);
    chk("scalar_tmo", 32'(rt), 32'd0);
    check_writes(wb, wq.size(), t, j, 0, 0);
    if (wq.size() >= wb + 4) begin
      chk("scalar_w1", wq[wb].d,   32'h00000200);
      chk("scalar_w2", wq[wb+1].d, 32'h00400030);
      chk("scalar_w3", wq[wb+2].d, 32'h00200018);
      chk("scalar_w4", wq[wb+3].d, 32'h00000003);
    end
    @(negedge clk); #1;
    chk("scalar_ready_after", 32'(cmd_ready), 32'd1);
    chk("scalar_resv_once", 32'(res_valid), 32'd0);

    // SIMD job; DONE from the previous run is still set while ARM waits
    bdly = 6; run_len = 5;
    j = rand_job(1'b0); j.m = 1'b1;
    perf_c = $urandom; perf_p = $urandom;
    chk("simd_stale_done", 32'(st_done), 32'd1);
    start_job(j, t, wb);
    wait_res("simd_res", 80);
    chk("simd_res_cyc", 32'(res_cyc), 32'(done_cyc + 3));
    chk("simd_cycles", rc, perf_c);
    if (wq.size() >= wb + 4) chk("simd_start", wq[wb+3].d, 32'h00000007);
    check_writes(wb, wq.size(), t, j, 0, 0);

    // stepping: three steps, plus one request dropped during STEP_WAIT
    bdly = 2;
    j = rand_job(1'b1); j.m = 1'b1;
    perf_c = $urandom; perf_p = $urandom;
    start_job(j, t, wb);
    wait_busy();
    cycles(3);
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      if (i == 0) pulse_step();
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin @(negedge clk); #1; seen = (steps > i) || st_done; end
      chk("step_seen", 32'(seen), 32'd1);
      cycles(2);
    end
    wait_res("step_res", 60);
    chk("step_cycles", rc, perf_c);
    chk("step_pixels", rp, perf_p);
    check_writes(wb, wq.size(), t, j, 3, 0);

    // timeout: stub never finishes
    never_done = 1;
    j = rand_job(1'b0);
    start_job(j, t, wb);
    wait_res("tmo_res", 100);
    chk("tmo_flag", 32'(rt), 32'd1);
    chk("tmo_cycles", rc, 32'd0);
    chk("tmo_pixels", rp, 32'd0);
    check_writes(wb, wq.size(), t, j, 0, 1);
    never_done = 0;
    cycles(3);

    // reset while polling, then a clean job
    run_len = 12;
    j = rand_job(1'b0);
    start_job(j, t, wb);
    wait_busy();
    cycles(2);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_we", 32'(csr_we), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    wb = wq.size();
    cycles(4);
    chk("mid_rst_no_write", 32'(wq.size() - wb), 32'd0);
    plain_job("post_rst", rand_job(1'b0));

    // cmd_valid held across two jobs; fields change while busy
    j = rand_job(1'b0); j2 = rand_job(1'b0);
    run_len = $urandom_range(3, 10);
    perf_c = $urandom; perf_p = $urandom;
    @(posedge clk); #1;
    wb1 = wq.size(); a0 = acc_q.size();
    drive_cmd(j); cmd_valid = 1'b1;
    for (int i = 0; i < 20 && acc_q.size() < a0 + 1; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1 drive_cmd(j2);
    for (int i = 0; i < 100 && acc_q.size() < a0 + 2; i++) begin @(negedge clk); #1; end
    d1 = done_cyc;
    @(posedge clk); #1 cmd_valid = 1'b0;
    chk("hold_two_acc", 32'(acc_q.size() - a0), 32'd2);
    t1 = (acc_q.size() > a0) ? acc_q[a0] : -1;
    t2 = (acc_q.size() > a0 + 1) ? acc_q[a0+1] : -1;
    chk("hold_spacing", 32'(t2), 32'(d1 + 4));
    wait_res("hold_res2", 80);
    cycles(5);
    chk("hold_acc_total", 32'(acc_q.size() - a0), 32'd2);
    chk("hold_cycles", rc, perf_c);
    wend = wb1;
    while (wend < wq.size() && wq[wend].c <= t2) wend++;
    check_writes(wb1, wend, t1, j, 0, 0);
    check_writes(wend, wq.size(), t2, j2, 0, 0);

    // a few random plain jobs
    for (int n = 0; n < 3; n++) plain_job("rand", rand_job(1'b0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/bilinear_csr_host.md
# bilinear_csr_host

Hardware CSR initiator for the bilinear downscale accelerator. It accepts one job descriptor (mode, dimensions, Q8.8 inverse scale), programs the accelerator's CSR bank, starts the run, and polls STATUS until DONE. In stepping mode it performs the STEP/STEP_ACK handshake on request. At the end it reads back PERF_CYC and PERF_PIX and returns them as a one-cycle result. It sits between a test sequencer or embedded controller and the accelerator's `csr_*` port.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1_000_000: maximum number of consecutive cycles spent waiting on accelerator STATUS before the job is aborted.
- `ARM_GUARD`, default 2: number of cycles after the START write before STATUS is first sampled.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: job request.
- `cmd_ready` out 1: high only in IDLE. A job is accepted on `cmd_valid && cmd_ready`.
- `cmd_mode` in 1: 0 = scalar, 1 = SIMD.
- `cmd_step_mode` in 1: enable stepping.
- `cmd_in_w`, `cmd_in_h`, `cmd_out_w`, `cmd_out_h` in 16 each: dimensions.
- `cmd_inv_scale_q` in 16: Q8.8 inverse scale.
- `step_req` in 1: single-cycle pulse requesting one step.
- `busy` out 1: high whenever the block is not in IDLE.
- `res_valid` out 1: one-cycle result strobe.
- `res_cycles`, `res_pixels` out 32 each: PERF readback. Held until the next job is accepted.
- `res_timeout` out 1: the job was aborted. Held with the result.
- `csr_we` out 1, `csr_addr` out 4, `csr_wdata` out 32: CSR write/address. All are registered.
- `csr_rdata` in 32: combinational read data for the current `csr_addr`.

## Operation
- CSR word map: CTRL=0, STATUS=1, SCALE_Q=2, IN_W_H=3, OUT_W_H=4, PERF_CYC=5, PERF_PIX=6.
- CTRL bits: EN[0], START[1], MODE[2], STEP_MODE[3], STEP[4].
- STATUS bits: BUSY[0], DONE[1], STEP_ACK[3].
- The descriptor is latched on accept. CTRL base value = EN | MODE<<2 | STEP_MODE<<3.

State machine:
- IDLE: accept a job, then go to WR_SCALE.
- Write sequence, one write per cycle:
  - WR_SCALE: {16'h0, inv_scale_q}.
  - WR_IN: {in_w, in_h}.
  - WR_OUT: {out_w, out_h}.
  - WR_START: base | START.
- ARM: wait `ARM_GUARD` cycles, then read STATUS each cycle until BUSY=1, then go to POLL. A stale DONE from a previous run is ignored here.
- POLL: read STATUS each cycle.
  - DONE=1 → RD_CYC.
  - Else, if step mode is on and `step_req` is sampled → STEP_SET.
- STEP_SET: write base | STEP, then STEP_WAIT.
- STEP_WAIT: read STATUS until STEP_ACK=1, then STEP_CLR.
- STEP_CLR: write base, then POLL.
- RD_CYC, RD_PIX: present addresses 5 and 6; sample `csr_rdata` at the end of each cycle. Then go to RESULT.
- RESULT: assert `res_valid` for one cycle, then IDLE.
- ABORT: write CTRL = 0, set `res_timeout`, set the result fields to 0, then RESULT.

Timeout counter:
- Counts in ARM (after the guard), STEP_WAIT, and POLL, but only while step mode is off. In step mode the wait for `step_req` is software time, not hardware time.
- Clears on every state change.
- Reaching `TIMEOUT_CYC - 1` forces ABORT.

Boundaries:
- `step_req` outside POLL, or with step mode off, is ignored and not queued.
- If DONE and `step_req` arrive in the same POLL cycle, DONE wins.
- `cmd_valid` while busy is not accepted and does not corrupt the latched descriptor.
- `rst` mid-job returns to IDLE immediately. No CTRL clean-up write is issued.

## Timing
- Reset values:
  - All outputs are 0, except `cmd_ready` = 1.
  - `csr_addr` = STATUS (1).
  - State = IDLE.
- Accept at cycle T produces the writes:
  - T+1: SCALE_Q.
  - T+2: IN_W_H.
  - T+3: OUT_W_H.
  - T+4: CTRL with START.
- `csr_we` is high in exactly those cycles and in STEP_SET, STEP_CLR and ABORT. It is 0 in all other states.
- STATUS is first sampled at T+5+ARM_GUARD.
- DONE sampled in cycle D gives RD_CYC at D+1, RD_PIX at D+2, and `res_valid` at D+3.
- `cmd_ready` returns at D+4.
- A step request seen in POLL at cycle S gives the STEP=1 write at S+1. The earliest STEP=0 write is at S+3.

## Structure
- Package `bilinear_csr_pkg` holds:
  - CSR address localparams.
  - CTRL and STATUS bit indices.
  - The state enum.
  - The Q8.8 width constant.
- Sub-module `bilinear_csr_timeout`: a loadable down-counter with clear, enable and expire outputs.
- Everything else is a single FSM with registered CSR outputs.

## Test plan
- Scalar job: 64×48 → 32×24, scale 16'h0200, against a BUSY-2/DONE stub. Required:
  - Writes T+1..T+4 carry 0x00000200, 0x00400030, 0x00200018, 0x00000003.
  - `res_cycles` and `res_pixels` equal the stub values 0x120 and 0x300.
- SIMD job. Required: the START write is 0x00000007. A stale DONE=1 during ARM is not taken as completion.
- Step mode: three `step_req` pulses, with the stub acking after 4 cycles. Required:
  - The CTRL sequence is 0x1D/0x0D repeated three times.
  - A `step_req` pulse during STEP_WAIT is dropped.
- Timeout with `TIMEOUT_CYC`=16 and the stub never raising DONE. Required:
  - An ABORT write of CTRL=0.
  - `res_timeout`=1 with `res_cycles`=0 and `res_pixels`=0.
- `rst` asserted in POLL. Required:
  - Next cycle `busy`=0, `csr_we`=0, `cmd_ready`=1.
  - A new job then runs cleanly.
- `cmd_valid` held high across two jobs. Required: exactly two accepts, spaced by the full job length.
